// File: rtl/code_ctrl_pkg.sv
// Shared types and helpers for the keypad code-entry controller.
package code_ctrl_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SET,
      VERIFY,
      CHECK,
      LOCKED
   } state_t;

   // Lowest-priority-wins is irrelevant here: callers only use it with exactly one bit set.
   function automatic logic [DIGIT_W-1:0] onehot_to_bin(input logic [9:0] oh);
      logic [DIGIT_W-1:0] b;
      b = '0;
      for (int i = 0; i < 10; i++) begin
         if (oh[i]) b = DIGIT_W'(i);
      end
      return b;
   endfunction

endpackage

// File: rtl/key_edge_arb.sv
// Rising-edge detection on debounced keypad levels plus per-cycle command/digit arbitration.
module key_edge_arb
   import code_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [9:0]         key_digit,
   input  logic               key_setup,
   input  logic               key_sure,
   input  logic               key_clear,
   output logic               cmd_clear,
   output logic               cmd_setup,
   output logic               cmd_sure,
   output logic               dig_ev,
   output logic [DIGIT_W-1:0] dig_val,
   output logic               conflict
);

   logic [9:0] digit_q;
   logic       setup_q, sure_q, clear_q;
   logic [9:0] dig_rise;
   logic       setup_rise, sure_rise, clear_rise, any_cmd, multi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_q <= '0;
         setup_q <= 1'b0;
         sure_q  <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         digit_q <= key_digit;
         setup_q <= key_setup;
         sure_q  <= key_sure;
         clear_q <= key_clear;
      end
   end

   always_comb begin
      dig_rise   = key_digit & ~digit_q;
      setup_rise = key_setup & ~setup_q;
      sure_rise  = key_sure & ~sure_q;
      clear_rise = key_clear & ~clear_q;
      any_cmd    = clear_rise | setup_rise | sure_rise;
      // More than one bit set: clearing the lowest set bit leaves something behind.
      multi      = |(dig_rise & (dig_rise - 10'd1));
      cmd_clear  = clear_rise;
      cmd_setup  = setup_rise & ~clear_rise;
      cmd_sure   = sure_rise & ~clear_rise & ~setup_rise;
      dig_ev     = (|dig_rise) & ~multi & ~any_cmd;
      conflict   = multi & ~any_cmd;
      dig_val    = onehot_to_bin(dig_rise);
   end

endmodule

// File: rtl/code_entry_ctrl.sv
// Code entry sequencer: collects digits, programs or verifies the stored code.
// Attempt counting and the lockout window exist only when LOCKOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for setup or first digit of an entry
// SET    | collecting a new code to store
// VERIFY | collecting an entry to compare
// CHECK  | one-cycle compare, emits code_ok / code_err
// LOCKED | too many failures, keys ignored until timer expires
module code_entry_ctrl
   import code_ctrl_pkg::*;
#(
   parameter int CODE_LEN    = 4,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 50000000,
   parameter int LOCK_W      = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] key_digit,
   input  logic       key_setup,
   input  logic       key_sure,
   input  logic       key_clear,
   output logic       digit_valid,
   output logic [3:0] digit_cnt,
   output logic [3:0] m_disp,
   output logic       code_stored,
   output logic       setup_mode,
   output logic       code_ok,
   output logic       code_err,
   output logic       key_conflict,
   output logic       locked,
   output logic [3:0] tries_left
);

   localparam int         BUF_W     = CODE_LEN * DIGIT_W;
   localparam logic [3:0] CNT_FULL  = 4'(CODE_LEN);
   localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);

   if (LOCK_W < 1 || LOCK_W > 31 || (64'(1) << LOCK_W) <= 64'(LOCK_CYCLES)) begin : g_bad_lock_w
      $error("LOCK_W too narrow for LOCK_CYCLES");
   end

   logic               cmd_clear, cmd_setup, cmd_sure, dig_ev, conflict;
   logic [DIGIT_W-1:0] dig_val;

   key_edge_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .key_digit (key_digit),
      .key_setup (key_setup),
      .key_sure  (key_sure),
      .key_clear (key_clear),
      .cmd_clear (cmd_clear),
      .cmd_setup (cmd_setup),
      .cmd_sure  (cmd_sure),
      .dig_ev    (dig_ev),
      .dig_val   (dig_val),
      .conflict  (conflict)
   );

   state_t           state, state_nx;
   logic [BUF_W-1:0] code_buf, buf_nx, code_reg, code_nx;
   logic [3:0]       cnt_nx, disp_nx;
   logic             stored_nx, dv_nx, ok_nx, err_nx, conf_nx;
   logic             do_clear, take;

`ifdef LOCKOUT_EN
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
   logic [LOCK_W-1:0] lock_cnt, lock_nx;
   logic [3:0]        tries_nx;
`endif

   always_comb begin
      state_nx  = state;
      buf_nx    = code_buf;
      code_nx   = code_reg;
      cnt_nx    = digit_cnt;
      disp_nx   = m_disp;
      stored_nx = code_stored;
      dv_nx     = 1'b0;
      ok_nx     = 1'b0;
      err_nx    = 1'b0;
      conf_nx   = conflict & (state != LOCKED);
      do_clear  = 1'b0;
      take      = 1'b0;
`ifdef LOCKOUT_EN
      tries_nx  = tries_left;
      lock_nx   = lock_cnt;
`endif
      case (state)
         IDLE: begin
            if (cmd_setup) begin
               state_nx = SET;
               do_clear = 1'b1;
            end else if (dig_ev && code_stored) begin
               state_nx = VERIFY;
               take     = 1'b1;
            end
         end
         SET: begin
            if (cmd_clear || cmd_setup) begin
               do_clear = 1'b1;
            end else if (cmd_sure && digit_cnt == CNT_FULL) begin
               code_nx   = code_buf;
               stored_nx = 1'b1;
               do_clear  = 1'b1;
               state_nx  = IDLE;
`ifdef LOCKOUT_EN
               tries_nx  = TRIES_MAX;
`endif
            end else if (dig_ev) begin
               take = 1'b1;
            end
         end
         VERIFY: begin
            if (cmd_clear) begin
               do_clear = 1'b1;
               state_nx = IDLE;
            end else if (cmd_sure) begin
               state_nx = CHECK;
            end else if (dig_ev) begin
               take = 1'b1;
            end
         end
         CHECK: begin
            do_clear = 1'b1;
            state_nx = IDLE;
            if (digit_cnt == CNT_FULL && code_buf == code_reg) begin
               ok_nx = 1'b1;
`ifdef LOCKOUT_EN
               tries_nx = TRIES_MAX;
`endif
            end else begin
               err_nx = 1'b1;
`ifdef LOCKOUT_EN
               tries_nx = tries_left - 4'd1;
               if (tries_left == 4'd1) begin
                  state_nx = LOCKED;
                  lock_nx  = LOCK_LOAD;
               end
`endif
            end
         end
         LOCKED: begin
`ifdef LOCKOUT_EN
            if (lock_cnt == '0) begin
               state_nx = IDLE;
               tries_nx = TRIES_MAX;
            end else begin
               lock_nx = lock_cnt - LOCK_W'(1);
            end
`else
            state_nx = IDLE;
`endif
         end
         default: state_nx = IDLE;
      endcase

      if (do_clear) begin
         buf_nx  = '0;
         cnt_nx  = '0;
         disp_nx = '0;
      end else if (take && digit_cnt < CNT_FULL) begin
         buf_nx  = (code_buf << DIGIT_W) | BUF_W'(dig_val);
         cnt_nx  = digit_cnt + 4'd1;
         disp_nx = dig_val;
         dv_nx   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         code_buf     <= '0;
         code_reg     <= '0;
         digit_cnt    <= '0;
         m_disp       <= '0;
         code_stored  <= 1'b0;
         setup_mode   <= 1'b0;
         digit_valid  <= 1'b0;
         code_ok      <= 1'b0;
         code_err     <= 1'b0;
         key_conflict <= 1'b0;
      end else begin
         state        <= state_nx;
         code_buf     <= buf_nx;
         code_reg     <= code_nx;
         digit_cnt    <= cnt_nx;
         m_disp       <= disp_nx;
         code_stored  <= stored_nx;
         setup_mode   <= (state_nx == SET);
         digit_valid  <= dv_nx;
         code_ok      <= ok_nx;
         code_err     <= err_nx;
         key_conflict <= conf_nx;
      end
   end

`ifdef LOCKOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tries_left <= TRIES_MAX;
         locked     <= 1'b0;
         lock_cnt   <= '0;
      end else begin
         tries_left <= tries_nx;
         locked     <= (state_nx == LOCKED);
         lock_cnt   <= lock_nx;
      end
   end
`else
   assign tries_left = TRIES_MAX;
   assign locked     = 1'b0;
`endif

endmodule
